// File: rtl/tlb_repl_ctrl.sv
// rtl/tlb_repl_ctrl.sv - 8-way TLB tree-PLRU replacement and PTW refill controller
// Optional hit/miss counters are built when TLB_REPL_PERF_EN is defined.
module tlb_repl_ctrl #(
    parameter int NWAYS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lookup_valid,
    input  logic [NWAYS-1:0]         lookup_hit,
    input  logic                     flush,
    output logic                     busy,
    output logic                     ptw_req_valid,
    input  logic                     ptw_req_ready,
    input  logic                     ptw_resp_valid,
    input  logic                     ptw_resp_err,
    output logic                     fill_valid,
    output logic [$clog2(NWAYS)-1:0] fill_way,
    output logic                     fault,
    output logic [NWAYS-1:0]         valid_vec,
    output logic [7:0]               plru_state
`ifdef TLB_REPL_PERF_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] valid_q, valid_d;
    logic [7:0] plru_q, plru_d;
    logic [2:0] fill_way_q, fill_way_d;
    logic       fault_q, fault_d;
    logic [2:0] hit_way;
    logic [2:0] victim_way;

    // Tree nodes live at indices 1..7, so bit 0 is never written.
    function automatic logic [7:0] plru_touch(input logic [7:0] s, input logic [2:0] w);
        logic [7:0] r;
        r = s;
        r[1]                  = ~w[2];
        r[{2'b01, w[2]}]      = ~w[1];
        r[{1'b1, w[2], w[1]}] = ~w[0];
        return r;
    endfunction

    function automatic logic [2:0] pick_victim(input logic [7:0] s, input logic [7:0] v);
        logic       b2;
        logic       b1;
        logic       b0;
        logic [2:0] res;
        b2  = s[1];
        b1  = s[{2'b01, b2}];
        b0  = s[{1'b1, b2, b1}];
        res = {b2, b1, b0};
        for (int i = 7; i >= 0; i--) begin
            if (!v[i]) begin
                res = i[2:0];
            end
        end
        return res;
    endfunction

    always_comb begin
        hit_way    = {|lookup_hit[7:4],
                      |{lookup_hit[7:6], lookup_hit[3:2]},
                      |{lookup_hit[7], lookup_hit[5], lookup_hit[3], lookup_hit[1]}};
        victim_way = pick_victim(plru_q, valid_q);
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        plru_d     = plru_q;
        fill_way_d = fill_way_q;
        fault_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lookup_valid) begin
                    if (|lookup_hit) begin
                        plru_d = plru_touch(plru_q, hit_way);
                    end else begin
                        fill_way_d = victim_way;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (ptw_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ptw_resp_valid) begin
                    if (ptw_resp_err) begin
                        fault_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                valid_d[fill_way_q] = 1'b1;
                plru_d              = plru_touch(plru_q, fill_way_q);
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush wins over everything, including a lookup in the same cycle.
        if (flush) begin
            state_d = ST_IDLE;
            valid_d = '0;
            plru_d  = '0;
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            plru_q     <= '0;
            fill_way_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            plru_q     <= plru_d;
            fill_way_q <= fill_way_d;
            fault_q    <= fault_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign ptw_req_valid = (state_q == ST_REQ);
    assign fill_valid    = (state_q == ST_FILL);
    assign fill_way      = fill_way_q;
    assign fault         = fault_q;
    assign valid_vec     = valid_q;
    assign plru_state    = plru_q;

`ifdef TLB_REPL_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        lookup_acc;

    always_comb begin
        lookup_acc   = !flush && (state_q == ST_IDLE) && lookup_valid;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (lookup_acc && (|lookup_hit)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (lookup_acc && !(|lookup_hit)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_tlb_repl_ctrl.sv
// tb/tb_tlb_repl_ctrl.sv - self-checking bench for tlb_repl_ctrl
module tb_tlb_repl_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lookup_valid = 1'b0;
    logic [7:0] lookup_hit = '0;
    logic       flush = 1'b0;
    logic       busy;
    logic       ptw_req_valid;
    logic       ptw_req_ready = 1'b0;
    logic       ptw_resp_valid = 1'b0;
    logic       ptw_resp_err = 1'b0;
    logic       fill_valid;
    logic [2:0] fill_way;
    logic       fault;
    logic [7:0] valid_vec;
    logic [7:0] plru_state;
`ifdef TLB_REPL_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    tlb_repl_ctrl #(.NWAYS(8)) dut (
        .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
        .flush(flush), .busy(busy), .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
        .ptw_resp_valid(ptw_resp_valid), .ptw_resp_err(ptw_resp_err), .fill_valid(fill_valid),
        .fill_way(fill_way), .fault(fault), .valid_vec(valid_vec), .plru_state(plru_state)
`ifdef TLB_REPL_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [7:0] hit, input logic rdy,
                         input logic rv, input logic err, input logic fl);
        lookup_valid = lv; lookup_hit = hit; ptw_req_ready = rdy;
        ptw_resp_valid = rv; ptw_resp_err = err; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: tree nodes as an array indexed 1..7, refill as a phase number.
    int          m_phase;
    bit          m_valid[8];
    bit          m_node[8];
    int          m_fw;
    bit          m_fault;
    int unsigned m_hits;
    int unsigned m_miss;

    function automatic logic [7:0] m_plru();
        logic [7:0] r = '0;
        for (int i = 1; i < 8; i++) r[i] = m_node[i];
        return r;
    endfunction

    function automatic logic [7:0] m_vvec();
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = m_valid[i];
        return r;
    endfunction

    task automatic m_touch(input int w);
        int w2 = w / 4;
        int w1 = (w / 2) % 2;
        int w0 = w % 2;
        m_node[1] = (w2 == 0);
        m_node[2 + w2] = (w1 == 0);
        m_node[4 + 2 * w2 + w1] = (w0 == 0);
    endtask

    function automatic int m_victim();
        int b2, b1, b0;
        for (int i = 0; i < 8; i++) if (!m_valid[i]) return i;
        b2 = m_node[1];
        b1 = m_node[2 + b2];
        b0 = m_node[4 + 2 * b2 + b1];
        return 4 * b2 + 2 * b1 + b0;
    endfunction

    function automatic int m_fold(input logic [7:0] h);
        return 4 * int'((h & 8'hF0) != 0) + 2 * int'((h & 8'hCC) != 0) + int'((h & 8'hAA) != 0);
    endfunction

    task automatic m_reset();
        m_phase = 0; m_fw = 0; m_fault = 0; m_hits = 0; m_miss = 0;
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_node[i] = 0; end
    endtask

    task automatic m_step();
        m_fault = 0;
        if (flush) begin
            m_phase = 0;
            for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_node[i] = 0; end
        end else begin
            case (m_phase)
                0: if (lookup_valid) begin
                    if (lookup_hit != 0) begin
                        m_touch(m_fold(lookup_hit)); m_hits++;
                    end else begin
                        m_fw = m_victim(); m_phase = 1; m_miss++;
                    end
                end
                1: if (ptw_req_ready) m_phase = 2;
                2: if (ptw_resp_valid) begin
                    if (ptw_resp_err) begin m_fault = 1; m_phase = 0; end
                    else m_phase = 3;
                end
                default: begin m_valid[m_fw] = 1; m_touch(m_fw); m_phase = 0; end
            endcase
        end
    endtask

    task automatic m_check();
        chk("rand_busy", busy, m_phase != 0);
        chk("rand_req", ptw_req_valid, m_phase == 1);
        chk("rand_fill", fill_valid, m_phase == 3);
        if (m_phase == 3) chk("rand_fill_way", fill_way, m_fw);
        chk("rand_fault", fault, m_fault);
        chk("rand_valid_vec", valid_vec, m_vvec());
        chk("rand_plru", plru_state, m_plru());
`ifdef TLB_REPL_PERF_EN
        chk("rand_hit_count", hit_count, m_hits);
        chk("rand_miss_count", miss_count, m_miss);
`endif
    endtask

    // Miss with minimum turnaround; lookups held high while busy must be ignored.
    task automatic do_miss(input logic [2:0] exp_way, input string tag);
        drive(1, 8'h00, 0, 0, 0, 0); step();
        chk({tag, "_req"}, ptw_req_valid, 1);
        chk({tag, "_victim"}, fill_way, exp_way);
        drive(1, 8'h01, 1, 0, 0, 0); step();
        chk({tag, "_wait_busy"}, busy, 1);
        drive(1, 8'h00, 0, 1, 0, 0); step();
        chk({tag, "_fill"}, fill_valid, 1);
        chk({tag, "_fill_way"}, fill_way, exp_way);
        drive(0, 8'h00, 0, 0, 0, 0); step();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_fill_done"}, fill_valid, 0);
    endtask

    typedef struct {
        logic       lv;
        logic [7:0] hit;
        logic       rdy, rv, err, fl;
        logic       e_busy, e_req, e_fill, e_fault;
        logic [2:0] e_fw;
        logic [7:0] e_valid, e_plru;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // lv hit rdy rv err fl | busy req fill fault fw valid plru
        vecs[0]  = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 8'h00, 8'h00};
        vecs[1]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 3'd0, 8'h00, 8'h00};
        vecs[2]  = '{0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 3'd0, 8'h00, 8'h00};
        vecs[3]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'h01, 8'h16};
        vecs[4]  = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 3'd1, 8'h01, 8'h16};
        vecs[5]  = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 3'd1, 8'h01, 8'h16};
        vecs[6]  = '{0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 1, 3'd1, 8'h01, 8'h16};
        vecs[7]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 8'h01, 8'h16};
        vecs[8]  = '{1, 8'h02, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 8'h01, 8'h06};
        vecs[9]  = '{1, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 3'd1, 8'h01, 8'h06};
        vecs[10] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 3'd1, 8'h01, 8'h06};
        vecs[11] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 3'd1, 8'h00, 8'h00};
        vecs[12] = '{0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 3'd1, 8'h00, 8'h00};
        vecs[13] = '{1, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 3'd1, 8'h00, 8'h00};

        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_req", ptw_req_valid, 0);
        chk("reset_fill", fill_valid, 0);
        chk("reset_fault", fault, 0);
        chk("reset_fill_way", fill_way, 0);
        chk("reset_valid_vec", valid_vec, 0);
        chk("reset_plru", plru_state, 0);
`ifdef TLB_REPL_PERF_EN
        chk("reset_hit_count", hit_count, 0);
        chk("reset_miss_count", miss_count, 0);
`endif

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].lv, vecs[i].hit, vecs[i].rdy, vecs[i].rv, vecs[i].err, vecs[i].fl);
            step();
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_req", i), ptw_req_valid, vecs[i].e_req);
            chk($sformatf("vec%0d_fill", i), fill_valid, vecs[i].e_fill);
            chk($sformatf("vec%0d_fault", i), fault, vecs[i].e_fault);
            if (vecs[i].e_fill || vecs[i].e_req) chk($sformatf("vec%0d_fill_way", i), fill_way, vecs[i].e_fw);
            chk($sformatf("vec%0d_valid_vec", i), valid_vec, vecs[i].e_valid);
            chk($sformatf("vec%0d_plru", i), plru_state, vecs[i].e_plru);
        end

        do_reset();
        for (int w = 0; w < 8; w++) do_miss(w[2:0], $sformatf("seq_miss%0d", w));
        chk("seq_full_valid", valid_vec, 8'hFF);
        chk("seq_full_plru", plru_state, 8'h00);
        do_miss(3'd0, "seq_miss9");
        drive(1, 8'h01, 0, 0, 0, 0); step();
        chk("seq_hit0_plru", plru_state, 8'h16);
        do_miss(3'd4, "seq_miss_after_hit");

        drive(1, 8'h00, 0, 0, 0, 0); step();
        drive(0, 8'h00, 1, 0, 0, 0); step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid_vec", valid_vec, 0);
        chk("async_rst_plru", plru_state, 0);
        chk("async_rst_fill_way", fill_way, 0);
        @(posedge clk); #1 rst_n = 1'b1;

`ifdef TLB_REPL_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h01 << i, 0, 0, 0, 0); step();
        end
        do_miss(3'd0, "perf_miss0");
        do_miss(3'd1, "perf_miss1");
        drive(0, 8'h00, 0, 0, 0, 1); step();
        drive(0, 8'h00, 0, 0, 0, 0); step();
        chk("perf_hit_count", hit_count, 3);
        chk("perf_miss_count", miss_count, 2);
`endif

        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom % 8;
            lookup_valid = $urandom % 2;
            if (r < 3) lookup_hit = 8'h00;
            else if (r == 7) lookup_hit = 8'($urandom);
            else lookup_hit = 8'h01 << ($urandom % 8);
            flush = ($urandom % 40) == 0;
            ptw_req_ready = $urandom % 2;
            ptw_resp_valid = ($urandom % 3) == 0;
            ptw_resp_err = ($urandom % 4) == 0;
            @(posedge clk);
            m_step();
            #1;
            m_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_repl_ctrl.md
# tlb_repl_ctrl

Replacement and refill controller for the 8-way fully-associative TLB. It holds the tree-PLRU state register and per-way valid bits, and updates the PLRU state on every lookup hit. On a miss it selects a victim way, runs the page-table-walker request/response handshake, and issues a single-cycle fill strobe to the TLB array. It sits between the TLB lookup stage (upstream) and the TLB entry array and PTW (downstream).

## Interface
Parameters:
- `NWAYS`, 8: number of ways; only 8 is supported, and the tree layout is fixed to 8 ways.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `lookup_valid`  in  1  lookup presented this cycle
- `lookup_hit`  in  8  one-hot hit vector; all zero means miss
- `flush`  in  1  sfence: invalidate all ways and abort any refill
- `busy`  out  1  controller not IDLE; upstream must hold `lookup_valid` low
- `ptw_req_valid`  out  1  walk request
- `ptw_req_ready`  in  1  PTW accepts the request
- `ptw_resp_valid`  in  1  walk response
- `ptw_resp_err`  in  1  walk faulted; qualified by `ptw_resp_valid`
- `fill_valid`  out  1  one-cycle write strobe to the TLB array
- `fill_way`  out  3  way index to write; valid while `fill_valid`
- `fault`  out  1  one-cycle pulse on an erroneous walk
- `valid_vec`  out  8  per-way valid bits
- `plru_state`  out  8  tree-PLRU register; bit 0 is unused and always 0

## Operation
PLRU encoding:
- Node 1 is the root, nodes 2–3 are the middle level, and nodes 4–7 are the leaves.
- Touching way w = {w2,w1,w0} sets three bits and leaves all others unchanged:
  - bit1 = ~w2
  - bit(2+w2) = ~w1
  - bit(4+2·w2+w1) = ~w0
- Victim tree walk:
  - b2 = s[1]
  - b1 = s[2+b2]
  - b0 = s[4+2·b2+b1]
  - victim = {b2,b1,b0}
- Victim choice:
  - If any `valid_vec` bit is 0, the victim is the lowest-index invalid way.
  - Otherwise the victim is the tree-walk result.

Hit encoding:
- `lookup_hit` is OR-folded: w2 = |hit[7:4]; w1 = |{hit[7:6],hit[3:2]}; w0 = |{hit[7],hit[5],hit[3],hit[1]}.
- A multi-hot vector is illegal. It is encoded deterministically by the fold above and is not flagged.

FSM states: IDLE, REQ, WAIT, FILL.
- IDLE:
  - `lookup_valid` with a nonzero hit: touch the hit way; stay in IDLE.
  - `lookup_valid` with a zero hit: latch the victim into `fill_way`; go to REQ.
- REQ: `ptw_req_valid`=1; on `ptw_req_ready`, go to WAIT.
- WAIT:
  - `ptw_resp_valid` with `ptw_resp_err`=0: go to FILL.
  - `ptw_resp_valid` with `ptw_resp_err`=1: pulse `fault`; go to IDLE. No fill; PLRU and valid bits unchanged.
- FILL: `fill_valid`=1 for exactly one cycle; set `valid_vec[fill_way]`; touch `fill_way`; go to IDLE.
- While busy, `lookup_valid` is ignored.
- `ptw_resp_valid` outside WAIT is ignored.

Flush (any state, highest priority):
- Next cycle: `valid_vec`=0, `plru_state`=0, state=IDLE.
- Any pending request or fill is dropped, and any same-cycle lookup is ignored.

Reset values: state=IDLE; `valid_vec`=0; `plru_state`=0; `fill_way`=0; `busy`, `ptw_req_valid`, `fill_valid` and `fault` all 0; perf counters 0.

## Timing
- All outputs are registered or decoded from registered state. `fill_way` is registered. There are no combinational paths from inputs to outputs.
- A hit updates `plru_state` on the edge ending the lookup cycle; the new value is visible the next cycle.
- Miss to `ptw_req_valid` high: 1 cycle.
- `ptw_req_valid` stays high until the cycle `ptw_req_ready` is sampled high.
- Response accepted to `fill_valid`: 1 cycle.
- `busy` is high from the cycle after the miss through the FILL cycle inclusive. A lookup is accepted again the cycle after FILL.
- Minimum miss turnaround (ready and response each in the first cycle they are possible): miss at cycle 0, REQ at cycle 1, WAIT at cycle 2, FILL at cycle 3, IDLE at cycle 4.
- Deasserting `rst_n` mid-refill returns the block to reset values immediately.

## Configuration
- `TLB_REPL_PERF_EN` defined:
  - Adds 32-bit outputs `hit_count` and `miss_count`.
  - They increment on accepted hits and accepted misses respectively, wrap modulo 2^32, and are cleared by reset only (not by flush).
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, miss → `ptw_req_valid` at cycle 1; ready at cycle 1; response at cycle 2 → `fill_valid`=1 with `fill_way`=0 at cycle 3, `valid_vec`=0x01, `plru_state`=0x16.
- Eight back-to-back error-free misses from reset → fills to ways 0..7 in order, `valid_vec`=0xFF, `plru_state`=0x00. A ninth miss → victim way 0.
- From that state, hit `lookup_hit`=0x01 → `plru_state`=0x16; then miss → `fill_way`=4.
- Miss with `ptw_resp_err`=1 → `fault` pulses one cycle, `fill_valid` never asserts, `valid_vec` and `plru_state` unchanged, `busy` drops.
- `flush` asserted during WAIT, followed by `ptw_resp_valid` → state IDLE, no fill, `valid_vec`=0, `plru_state`=0, the response ignored.
- With `TLB_REPL_PERF_EN`: 3 hits, 2 misses, 1 flush → `hit_count`=3, `miss_count`=2. `lookup_valid` asserted while busy is not counted.
